// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped 16x32B write-back, write-allocate data cache controller
module dcache_controller (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cpu_req_i,
    input  logic         cpu_write_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    output logic [31:0]  cpu_data_o,
    output logic         cpu_stall_o,
    output logic         mem_req_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i
);
    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;
    state_t r_state, w_next;
    logic [15:0]  r_valid, r_dirty;
    logic [22:0]  r_tag [16];
    logic [255:0] r_data [16];
    logic [22:0]  w_tag;
    logic [3:0]   w_idx;
    logic [7:0]   w_bit;
    logic [255:0] w_line, w_merged;
    logic [31:0]  w_rword;
    logic         w_hit, w_wr_hit, w_fill;
    assign w_tag    = cpu_addr_i[31:9];
    assign w_idx    = cpu_addr_i[8:5];
    assign w_bit    = {cpu_addr_i[4:2], 5'b0};
    assign w_line   = r_data[w_idx];
    assign w_rword  = w_line[w_bit +: 32];
    assign w_hit    = cpu_req_i & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign w_wr_hit = (r_state == IDLE) & w_hit & cpu_write_i;
    assign w_fill   = (r_state == ALLOCATE) & mem_ack_i;
    // line image with the store word spliced in
    always_comb begin
        w_merged = w_line;
        w_merged[w_bit +: 32] = cpu_data_i;
    end
    // state register; reset aborts any memory transaction immediately
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= IDLE;
        else        r_state <= w_next;
    end
    // next state and all outputs
    always_comb begin
        w_next      = r_state;
        cpu_stall_o = 1'b1;
        cpu_data_o  = '0;
        mem_req_o   = 1'b0;
        mem_write_o = 1'b0;
        mem_addr_o  = '0;
        mem_data_o  = '0;
        case (r_state)
            IDLE: begin
                cpu_stall_o = cpu_req_i & ~w_hit;
                cpu_data_o  = (w_hit & ~cpu_write_i) ? w_rword : '0;
                if (cpu_req_i & ~w_hit)
                    w_next = (r_valid[w_idx] & r_dirty[w_idx]) ? WRITEBACK : ALLOCATE;
            end
            WRITEBACK: begin
                mem_req_o   = 1'b1;
                mem_write_o = 1'b1;
                mem_addr_o  = {r_tag[w_idx], w_idx, 5'b0};
                mem_data_o  = w_line;
                if (mem_ack_i) w_next = ALLOCATE;
            end
            ALLOCATE: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {w_tag, w_idx, 5'b0};
                if (mem_ack_i) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end
    // valid/dirty bits, cleared by reset
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (w_fill) begin
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
        end else if (w_wr_hit) begin
            r_dirty[w_idx] <= 1'b1;
        end
    end
    // tag and data arrays: refill on ack, word write on store hit
    always_ff @(posedge clk_i) begin
        if (w_fill) begin
            r_tag[w_idx]  <= w_tag;
            r_data[w_idx] <= mem_data_i;
        end else if (w_wr_hit) begin
            r_data[w_idx] <= w_merged;
        end
    end
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed checks of hit/miss, writeback, stall and reset behaviour
module tb_dcache_controller;
    logic         clk_i = 1'b0;
    logic         rst_i, cpu_req_i, cpu_write_i, mem_ack_i;
    logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o, mem_addr_o;
    logic         cpu_stall_o, mem_req_o, mem_write_o;
    logic [255:0] mem_data_o, mem_data_i;
    int n_cmp = 0;
    int n_err = 0;
    logic [255:0] b1, b1m, b2, b3;

    dcache_controller dut (
        .clk_i(clk_i), .rst_i(rst_i), .cpu_req_i(cpu_req_i), .cpu_write_i(cpu_write_i),
        .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
        .cpu_stall_o(cpu_stall_o), .mem_req_o(mem_req_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
        .mem_ack_i(mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk_i);
    endtask

    initial begin
        b1 = {32'h77777777, 32'h66666666, 32'h55555555, 32'h44444444,
              32'h33333333, 32'hDEADBEEF, 32'h11111111, 32'h10101010};
        b1m = b1;
        b1m[31:0] = 32'h12345678;
        b2 = {224'h0, 32'hCAFEF00D};
        b3 = {192'h0, 32'h0BADC0DE, 32'h600DF00D};
        rst_i = 1'b0; cpu_req_i = 1'b0; cpu_write_i = 1'b0; cpu_addr_i = '0;
        cpu_data_i = '0; mem_ack_i = 1'b0; mem_data_i = '0;
        #1;
        check("rst_stall", cpu_stall_o, 0);
        check("rst_mreq", mem_req_o, 0);
        check("rst_mwr", mem_write_o, 0);
        check("rst_data", cpu_data_o, 0);
        cyc; rst_i = 1'b1;
        // clean load miss with a 10-cycle refill wait
        cyc; cpu_req_i = 1'b1; cpu_addr_i = 32'h40; #1;
        check("miss_stall", cpu_stall_o, 1);
        check("miss_idle_mreq", mem_req_o, 0);
        for (int i = 0; i < 10; i++) begin
            cyc; #1;
            check("alloc_wait_stall", cpu_stall_o, 1);
            check("alloc_wait_req", mem_req_o, 1);
            check("alloc_wait_wr", mem_write_o, 0);
            check("alloc_wait_addr", mem_addr_o, 32'h40);
        end
        cyc; mem_ack_i = 1'b1; mem_data_i = b1; #1;
        check("alloc_ack_stall", cpu_stall_o, 1);
        check("alloc_ack_addr", mem_addr_o, 32'h40);
        cyc; mem_ack_i = 1'b0; cpu_addr_i = 32'h48; #1;
        check("hit48_stall", cpu_stall_o, 0);
        check("hit48_data", cpu_data_o, 32'hDEADBEEF);
        check("hit48_mreq", mem_req_o, 0);
        // store hit then load back
        cyc; cpu_write_i = 1'b1; cpu_addr_i = 32'h40; cpu_data_i = 32'h12345678; #1;
        check("st_hit_stall", cpu_stall_o, 0);
        check("st_hit_data", cpu_data_o, 0);
        cyc; cpu_write_i = 1'b0; #1;
        check("ld40_data", cpu_data_o, 32'h12345678);
        check("ld40_stall", cpu_stall_o, 0);
        // conflict miss on a dirty line
        cyc; cpu_addr_i = 32'h240; #1;
        check("conf_stall", cpu_stall_o, 1);
        cyc; #1;
        check("wb_req", mem_req_o, 1);
        check("wb_wr", mem_write_o, 1);
        check("wb_addr", mem_addr_o, 32'h40);
        check("wb_data", mem_data_o, b1m);
        check("wb_stall", cpu_stall_o, 1);
        cyc; mem_ack_i = 1'b1; #1;
        check("wb_ack_addr", mem_addr_o, 32'h40);
        check("wb_ack_stall", cpu_stall_o, 1);
        cyc; mem_ack_i = 1'b0; #1;
        check("al2_wr", mem_write_o, 0);
        check("al2_addr", mem_addr_o, 32'h240);
        check("al2_stall", cpu_stall_o, 1);
        cyc; mem_ack_i = 1'b1; mem_data_i = b2; #1;
        check("al2_ack_stall", cpu_stall_o, 1);
        cyc; mem_ack_i = 1'b0; #1;
        check("hit240_data", cpu_data_o, 32'hCAFEF00D);
        check("hit240_stall", cpu_stall_o, 0);
        // spurious ack while idle
        cyc; cpu_req_i = 1'b0; mem_ack_i = 1'b1; mem_data_i = '1; #1;
        check("spur_stall", cpu_stall_o, 0);
        check("spur_mreq", mem_req_o, 0);
        check("spur_data", cpu_data_o, 0);
        cyc; mem_ack_i = 1'b0; cpu_req_i = 1'b1; #1;
        check("spur_after_data", cpu_data_o, 32'hCAFEF00D);
        check("spur_after_stall", cpu_stall_o, 0);
        // dirty the line, start a writeback, then reset in the middle of it
        cyc; cpu_write_i = 1'b1; cpu_addr_i = 32'h244; cpu_data_i = 32'hAAAA5555; #1;
        check("st244_stall", cpu_stall_o, 0);
        cyc; cpu_write_i = 1'b0; cpu_addr_i = 32'h40; #1;
        check("conf2_stall", cpu_stall_o, 1);
        cyc; #1;
        check("wb2_wr", mem_write_o, 1);
        check("wb2_addr", mem_addr_o, 32'h240);
        check("wb2_word1", mem_data_o[63:32], 32'hAAAA5555);
        cyc; rst_i = 1'b0; cpu_req_i = 1'b0; #1;
        check("mrst_mreq", mem_req_o, 0);
        check("mrst_mwr", mem_write_o, 0);
        check("mrst_stall", cpu_stall_o, 0);
        cyc; rst_i = 1'b1; cpu_req_i = 1'b1; cpu_addr_i = 32'h240; #1;
        check("post_rst_stall", cpu_stall_o, 1);
        cyc; #1;
        check("post_rst_wr", mem_write_o, 0);
        check("post_rst_addr", mem_addr_o, 32'h240);
        cyc; mem_ack_i = 1'b1; mem_data_i = b3;
        cyc; mem_ack_i = 1'b0; #1;
        check("post_rst_hit", cpu_data_o, 32'h600DF00D);
        check("post_rst_hstall", cpu_stall_o, 0);
        // store miss on a clean line: allocate then write
        cyc; cpu_write_i = 1'b1; cpu_addr_i = 32'h48; cpu_data_i = 32'h00000077; #1;
        check("stm_stall", cpu_stall_o, 1);
        cyc; #1;
        check("stm_wr", mem_write_o, 0);
        check("stm_addr", mem_addr_o, 32'h40);
        cyc; mem_ack_i = 1'b1; mem_data_i = b1;
        cyc; mem_ack_i = 1'b0; #1;
        check("stm_done_stall", cpu_stall_o, 0);
        cyc; cpu_write_i = 1'b0; #1;
        check("stm_ld48", cpu_data_o, 32'h00000077);
        cyc; cpu_addr_i = 32'h40; #1;
        check("stm_ld40", cpu_data_o, 32'h10101010);
        cyc; cpu_req_i = 1'b0; #1;
        check("idle_data", cpu_data_o, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
